evict_enq: RTL and testbench
============================

EVICT_ENQ -- requirements
Module: evict_enq

Interface
REQ-001 Parameters: ADDR_WIDTH, default `AXI_ADDR_WIDTH, evict address width; DATA_WIDTH, default `AXI_DATA_WIDTH, cache-line data width; ID_WIDTH, default `AXI_ID_WIDTH, AXI ID width; ID, default `AXI_ID, eviction-path AXI ID; MAX_OUTSTANDING, default 16, writes in flight before back-pressure; LINE_OFFSET, default 6, low address bits cleared for 64 B line alignment.
REQ-002 The block SHALL have exactly one clock, clk (input, 1 bit), and one reset, rst_n (input, 1 bit); reset is synchronous and active-low.
REQ-003 victim_valid_i, input, 1: victim request from the cache controller.
REQ-004 victim_ready_o, output, 1: request accepted in any cycle where valid and ready are both high.
REQ-005 victim_addr_i, input, ADDR_WIDTH: victim line address.
REQ-006 victim_data_i, input, DATA_WIDTH: victim line data.
REQ-007 victim_dirty_i, input, 1: victim line is dirty.
REQ-008 awfifo_afull_i, input, 1: AW FIFO almost full.
REQ-009 awfifo_wren_o, output, 1: AW FIFO write enable.
REQ-010 awfifo_data_o, output, ADDR_WIDTH: AW FIFO write data.
REQ-011 wfifo_afull_i, input, 1: W FIFO almost full.
REQ-012 wfifo_wren_o, output, 1: W FIFO write enable.
REQ-013 wfifo_data_o, output, DATA_WIDTH: W FIFO write data.
REQ-014 bid_i, input, ID_WIDTH: write-response ID from the CXL controller.
REQ-015 bvalid_i, input, 1: write-response valid.
REQ-016 bready_o, output, 1: write-response ready.
REQ-017 outstanding_o, output, $clog2(MAX_OUTSTANDING+1): evictions enqueued but not yet acknowledged.
REQ-018 idle_o, output, 1: FSM is in S_IDLE and outstanding is 0.
REQ-019 err_o, output, 1: sticky flag for an unexpected response.

Function
REQ-020 The FSM SHALL have three states: S_IDLE, S_HOLD and S_WRITE.
REQ-021 victim_ready_o SHALL be 1 only when the FSM is in S_IDLE and outstanding < MAX_OUTSTANDING.
REQ-022 On an accepted dirty request, the block SHALL latch the address with bits [LINE_OFFSET-1:0] cleared, latch the data, and go to S_HOLD.
REQ-023 On an accepted clean request, the block SHALL drop the request, make no FIFO write, and stay in S_IDLE.
REQ-024 In S_HOLD, when awfifo_afull_i and wfifo_afull_i are both 0, the block SHALL go to S_WRITE; otherwise it SHALL stay in S_HOLD and hold the latched data.
REQ-025 In S_WRITE, awfifo_wren_o and wfifo_wren_o SHALL both be 1 for exactly one cycle, with the latched address and data on awfifo_data_o and wfifo_data_o; the next state SHALL be S_IDLE.
REQ-026 Both wren outputs SHALL be registered and SHALL never assert independently of each other.
REQ-027 Minimum latency SHALL be: accept in cycle N, wren in cycle N+2, ready again in cycle N+3.
REQ-028 bready_o SHALL be 1 in every cycle after reset.
REQ-029 A response is a cycle where bvalid_i, bready_o are 1 and bid_i equals ID.
REQ-030 Responses whose bid_i is not ID SHALL be consumed and otherwise ignored.
REQ-031 The outstanding count SHALL increment by 1 in each S_WRITE cycle and decrement by 1 on each response.
REQ-032 A write and a response in the same cycle SHALL leave the count unchanged.
REQ-033 A response while the count is 0 SHALL leave the count at 0 and set err_o; err_o stays set until reset.
REQ-034 The count SHALL never exceed MAX_OUTSTANDING, guaranteed by REQ-021.
REQ-035 awfifo_data_o and wfifo_data_o SHALL hold their last values while wren is 0.

Reset
REQ-036 On reset: state is S_IDLE; victim_ready_o, awfifo_wren_o, wfifo_wren_o, bready_o, err_o and outstanding_o are 0; awfifo_data_o and wfifo_data_o are 0; idle_o is 1.
REQ-037 Reset mid-operation SHALL discard any latched victim and zero the count, with no wren in the cycle after reset.

Structure
REQ-038 The widths, ID, MAX_OUTSTANDING, LINE_OFFSET and the state encoding SHALL live in the shared TYPEDEF.svh package.
REQ-039 The outstanding counter SHALL be one sub-module, evict_credit_cnt (inc, dec, count, underflow).
REQ-040 The FIFOs and evict_aw_w SHALL be instantiated outside this block.

Verification
REQ-041 Dirty victim at addr 0x1234_5678, data 0xA5..A5, FIFOs not full -> one wren pulse at N+2 with awfifo_data 0x1234_5640, wfifo_data 0xA5..A5; outstanding 1.
REQ-042 Clean victim -> accepted, no wren, outstanding unchanged, idle_o stays 1.
REQ-043 awfifo_afull_i high for 5 cycles during S_HOLD -> no wren and data held; wren one cycle after afull drops.
REQ-044 16 dirty victims, no responses -> victim_ready_o 0 at outstanding 16; one bid=ID response -> ready returns and count is 15.
REQ-045 Write and matching response in the same cycle -> count unchanged; bid≠ID response -> count unchanged, err_o 0; response at count 0 -> err_o 1.
REQ-046 rst_n low during S_HOLD -> no wren afterwards, outstanding 0, idle_o 1.

Source files
------------

// File: rtl/evict_enq_pkg.sv
// Shared definitions for the eviction enqueue path: default bus widths,
// the eviction-path AXI ID, credit depth, line alignment and FSM encoding.
package evict_enq_pkg;

    localparam int unsigned AXI_ADDR_WIDTH        = 32;
    localparam int unsigned AXI_DATA_WIDTH        = 512;
    localparam int unsigned AXI_ID_WIDTH          = 4;
    localparam int unsigned AXI_ID                = 2;
    localparam int unsigned EVICT_MAX_OUTSTANDING = 16;
    localparam int unsigned EVICT_LINE_OFFSET     = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_WRITE = 2'd2
    } evict_state_e;

endpackage

// File: rtl/evict_credit_cnt.sv
// Outstanding-eviction credit counter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : one write enqueued this cycle
//   dec        : one write acknowledged this cycle
//   count      : writes enqueued but not yet acknowledged
//   underflow  : acknowledge with nothing outstanding (single-cycle pulse)
module evict_credit_cnt #(
    parameter int unsigned MAX   = 16,
    parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    // A simultaneous inc/dec cancels out, so only a lone dec can underflow.
    assign underflow = dec && !inc && (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/evict_enq.sv
// Eviction enqueue: accepts victim lines from the cache controller, drops
// clean ones, and pushes dirty ones as a paired AW/W FIFO write once both
// FIFOs have room. Tracks write responses for the eviction ID.
//   victim_*     : victim request handshake, line address/data/dirty flag
//   awfifo_*     : AW FIFO almost-full in, write enable and address out
//   wfifo_*      : W FIFO almost-full in, write enable and data out
//   bid_i/bvalid_i/bready_o : write-response channel
//   outstanding_o: enqueued writes awaiting response
//   idle_o       : nothing latched and nothing outstanding
//   err_o        : sticky, response seen with nothing outstanding
module evict_enq
    import evict_enq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = AXI_DATA_WIDTH,
    parameter int unsigned ID_WIDTH        = AXI_ID_WIDTH,
    parameter int unsigned ID              = AXI_ID,
    parameter int unsigned MAX_OUTSTANDING = EVICT_MAX_OUTSTANDING,
    parameter int unsigned LINE_OFFSET     = EVICT_LINE_OFFSET
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   victim_valid_i,
    output logic                                   victim_ready_o,
    input  logic [ADDR_WIDTH-1:0]                  victim_addr_i,
    input  logic [DATA_WIDTH-1:0]                  victim_data_i,
    input  logic                                   victim_dirty_i,
    input  logic                                   awfifo_afull_i,
    output logic                                   awfifo_wren_o,
    output logic [ADDR_WIDTH-1:0]                  awfifo_data_o,
    input  logic                                   wfifo_afull_i,
    output logic                                   wfifo_wren_o,
    output logic [DATA_WIDTH-1:0]                  wfifo_data_o,
    input  logic [ID_WIDTH-1:0]                    bid_i,
    input  logic                                   bvalid_i,
    output logic                                   bready_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   idle_o,
    output logic                                   err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'((64'd1 << LINE_OFFSET) - 64'd1);

    evict_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [ADDR_WIDTH-1:0] aw_data_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic                  wren_q;
    logic                  run_q;
    logic                  err_q;
    logic [CNT_W-1:0]      count;
    logic                  underflow;
    logic                  accept;
    logic                  take_dirty;
    logic                  fifo_room;
    logic                  rsp;

    // run_q rises on the first clock after reset; it gates both ready
    // outputs so they are low throughout reset.
    assign fifo_room      = !awfifo_afull_i && !wfifo_afull_i;
    assign victim_ready_o = run_q && (state_q == S_IDLE) &&
                            (count < CNT_W'(MAX_OUTSTANDING));
    assign accept         = victim_valid_i && victim_ready_o;
    assign take_dirty     = accept && victim_dirty_i;
    assign rsp            = bvalid_i && run_q && (bid_i == ID_WIDTH'(ID));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (take_dirty) state_d = S_HOLD;
            S_HOLD:  if (fifo_room)  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The write pulse is registered on the HOLD->WRITE transition, so
    // wren_q is high exactly while the FSM sits in S_WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            aw_data_q   <= '0;
            w_data_q    <= '0;
            wren_q      <= 1'b0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (take_dirty) begin
                hold_addr_q <= victim_addr_i & LINE_MASK;
                hold_data_q <= victim_data_i;
            end
            wren_q <= (state_q == S_HOLD) && fifo_room;
            if ((state_q == S_HOLD) && fifo_room) begin
                aw_data_q <= hold_addr_q;
                w_data_q  <= hold_data_q;
            end
            if (underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    evict_credit_cnt #(
        .MAX   (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (wren_q),
        .dec       (rsp),
        .count     (count),
        .underflow (underflow)
    );

    assign awfifo_wren_o = wren_q;
    assign wfifo_wren_o  = wren_q;
    assign awfifo_data_o = aw_data_q;
    assign wfifo_data_o  = w_data_q;
    assign bready_o      = run_q;
    assign outstanding_o = count;
    assign idle_o        = (state_q == S_IDLE) && (count == '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_evict_enq.sv
module tb_evict_enq;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 512;
    localparam int unsigned IDW = 4;
    localparam int unsigned MY_ID = 2;
    localparam int unsigned CW  = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           victim_valid_i;
    logic           victim_ready_o;
    logic [AW-1:0]  victim_addr_i;
    logic [DW-1:0]  victim_data_i;
    logic           victim_dirty_i;
    logic           awfifo_afull_i;
    logic           awfifo_wren_o;
    logic [AW-1:0]  awfifo_data_o;
    logic           wfifo_afull_i;
    logic           wfifo_wren_o;
    logic [DW-1:0]  wfifo_data_o;
    logic [IDW-1:0] bid_i;
    logic           bvalid_i;
    logic           bready_o;
    logic [CW-1:0]  outstanding_o;
    logic           idle_o;
    logic           err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    evict_enq #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ID_WIDTH        (IDW),
        .ID              (MY_ID),
        .MAX_OUTSTANDING (16),
        .LINE_OFFSET     (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .victim_valid_i (victim_valid_i),
        .victim_ready_o (victim_ready_o),
        .victim_addr_i  (victim_addr_i),
        .victim_data_i  (victim_data_i),
        .victim_dirty_i (victim_dirty_i),
        .awfifo_afull_i (awfifo_afull_i),
        .awfifo_wren_o  (awfifo_wren_o),
        .awfifo_data_o  (awfifo_data_o),
        .wfifo_afull_i  (wfifo_afull_i),
        .wfifo_wren_o   (wfifo_wren_o),
        .wfifo_data_o   (wfifo_data_o),
        .bid_i          (bid_i),
        .bvalid_i       (bvalid_i),
        .bready_o       (bready_o),
        .outstanding_o  (outstanding_o),
        .idle_o         (idle_o),
        .err_o          (err_o)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wren(input string tag, input logic exp);
        check({tag, " aw_wren"}, DW'(awfifo_wren_o), DW'(exp));
        check({tag, " w_wren"},  DW'(wfifo_wren_o),  DW'(exp));
    endtask

    task automatic respond(input logic [IDW-1:0] id);
        bvalid_i = 1'b1;
        bid_i    = id;
        tick();
        bvalid_i = 1'b0;
    endtask

    // Accept one dirty victim with FIFOs free; returns in the first cycle
    // after the write pulse (back in S_IDLE).
    task automatic push_dirty(input logic [AW-1:0] a);
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b1;
        victim_addr_i  = a;
        tick();
        victim_valid_i = 1'b0;
        tick();
        tick();
    endtask

    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_5a;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_5a = {64{8'h5A}};
        rst_n = 1'b0;
        victim_valid_i = 1'b0;
        victim_addr_i  = '0;
        victim_data_i  = '0;
        victim_dirty_i = 1'b0;
        awfifo_afull_i = 1'b0;
        wfifo_afull_i  = 1'b0;
        bid_i    = '0;
        bvalid_i = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst ready",  DW'(victim_ready_o), '0);
        check_wren("rst", 1'b0);
        check("rst bready", DW'(bready_o), '0);
        check("rst err",    DW'(err_o), '0);
        check("rst cnt",    DW'(outstanding_o), '0);
        check("rst awdata", DW'(awfifo_data_o), '0);
        check("rst wdata",  wfifo_data_o, '0);
        check("rst idle",   DW'(idle_o), DW'(1));
        rst_n = 1'b1;
        tick();
        check("post bready", DW'(bready_o), DW'(1));

        // Dirty victim: accept at N, wren at N+2, ready at N+3
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b1;
        victim_addr_i  = 32'h1234_5678;
        victim_data_i  = pat_a5;
        check("n ready", DW'(victim_ready_o), DW'(1));
        tick();
        victim_valid_i = 1'b0;
        check_wren("n+1", 1'b0);
        check("n+1 ready", DW'(victim_ready_o), '0);
        tick();
        check_wren("n+2", 1'b1);
        check("n+2 awdata", DW'(awfifo_data_o), DW'(32'h1234_5640));
        check("n+2 wdata",  wfifo_data_o, pat_a5);
        tick();
        check_wren("n+3", 1'b0);
        check("n+3 ready",  DW'(victim_ready_o), DW'(1));
        check("n+3 cnt",    DW'(outstanding_o), DW'(1));
        check("n+3 idle",   DW'(idle_o), '0);
        check("n+3 awhold", DW'(awfifo_data_o), DW'(32'h1234_5640));
        respond(IDW'(MY_ID));
        check("rsp cnt",  DW'(outstanding_o), '0);
        check("rsp idle", DW'(idle_o), DW'(1));

        // Clean victim is accepted and dropped
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b0;
        victim_addr_i  = 32'h0BAD_0000;
        check("clean ready", DW'(victim_ready_o), DW'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            victim_valid_i = 1'b0;
            check_wren("clean", 1'b0);
            check("clean idle", DW'(idle_o), DW'(1));
        end
        check("clean cnt", DW'(outstanding_o), '0);

        // AW FIFO almost full during S_HOLD
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b1;
        victim_addr_i  = 32'hDEAD_BEEF;
        victim_data_i  = pat_5a;
        awfifo_afull_i = 1'b1;
        tick();
        victim_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_wren("afull", 1'b0);
            check("afull awhold", DW'(awfifo_data_o), DW'(32'h1234_5640));
            check("afull whold",  wfifo_data_o, pat_a5);
            tick();
        end
        awfifo_afull_i = 1'b0;
        tick();
        check_wren("afull drop", 1'b1);
        check("afull awdata", DW'(awfifo_data_o), DW'(32'hDEAD_BEC0));
        check("afull wdata",  wfifo_data_o, pat_5a);
        tick();
        check("afull cnt", DW'(outstanding_o), DW'(1));
        respond(IDW'(MY_ID));
        check("afull cnt0", DW'(outstanding_o), '0);

        // Fill to 16 outstanding, ready must drop
        for (int i = 0; i < 16; i++) begin
            push_dirty(AW'(i) << 6);
        end
        check("full cnt",   DW'(outstanding_o), DW'(16));
        check("full ready", DW'(victim_ready_o), '0);
        victim_valid_i = 1'b1;
        tick();
        tick();
        victim_valid_i = 1'b0;
        check_wren("full blocked", 1'b0);
        check("full cnt hold", DW'(outstanding_o), DW'(16));
        respond(IDW'(MY_ID));
        check("full cnt15",   DW'(outstanding_o), DW'(15));
        check("full ready15", DW'(victim_ready_o), DW'(1));

        // Write and matching response in the same cycle
        victim_valid_i = 1'b1;
        victim_addr_i  = 32'h0000_1000;
        tick();
        victim_valid_i = 1'b0;
        tick();
        check_wren("same wren", 1'b1);
        respond(IDW'(MY_ID));
        check("same cnt", DW'(outstanding_o), DW'(15));

        // Foreign-ID response is ignored
        respond(IDW'(MY_ID ^ 1));
        check("foreign cnt", DW'(outstanding_o), DW'(15));
        check("foreign err", DW'(err_o), '0);

        // Drain, then underflow
        for (int i = 0; i < 15; i++) begin
            respond(IDW'(MY_ID));
        end
        check("drain cnt",  DW'(outstanding_o), '0);
        check("drain err",  DW'(err_o), '0);
        check("drain idle", DW'(idle_o), DW'(1));
        respond(IDW'(MY_ID));
        check("uflow cnt", DW'(outstanding_o), '0);
        check("uflow err", DW'(err_o), DW'(1));
        tick();
        check("uflow sticky", DW'(err_o), DW'(1));

        // Reset while holding a victim
        awfifo_afull_i = 1'b1;
        victim_valid_i = 1'b1;
        victim_addr_i  = 32'hCAFE_0040;
        tick();
        victim_valid_i = 1'b0;
        check("hold idle", DW'(idle_o), '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        awfifo_afull_i = 1'b0;
        check_wren("rst hold", 1'b0);
        check("rst hold err", DW'(err_o), '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_wren("after rst", 1'b0);
            check("after rst cnt",  DW'(outstanding_o), '0);
            check("after rst idle", DW'(idle_o), DW'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
